// File: rtl/f6_pkg.sv
// Shared types and constants for the F6 actuator ADC acquisition path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package f6_pkg;

   // Frame sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // clk_adc periods per conversion frame
   localparam int ADC_FRAME_CLKS   = 15;
   // clk_adc period that carries the null bit; data bits follow it MSB-first
   localparam int ADC_NULL_BIT_IDX = 3;
   // ADC result width
   localparam int ADC_BITS         = 12;

endpackage : f6_pkg

// File: rtl/f6_adc_acq_if.sv
// Bundles the ADC pins, the control inputs and the sample output of the acquisition block.
// Latency: n/a (wiring only).
// Backpressure: none; the sample consumer must take adc_data on the adc_valid strobe.
import f6_pkg::*;

interface f6_adc_acq_if #(
   parameter int N_BITS = ADC_BITS
);
   logic              start;
   logic              continuous;
   logic              data_in;
   logic              clk_adc;
   logic              cs_n;
   logic [N_BITS-1:0] adc_data;
   logic              adc_valid;
   logic              null_err;
   logic              busy;

   // Acquisition block side: takes requests and DOUT, drives the ADC and the sample
   modport master (
      input  start,
      input  continuous,
      input  data_in,
      output clk_adc,
      output cs_n,
      output adc_data,
      output adc_valid,
      output null_err,
      output busy
   );

   // Environment side: issues requests, models the ADC, consumes samples
   modport slave (
      output start,
      output continuous,
      output data_in,
      input  clk_adc,
      input  cs_n,
      input  adc_data,
      input  adc_valid,
      input  null_err,
      input  busy
   );
endinterface : f6_adc_acq_if

// File: rtl/f6_sync2.sv
// Two-flop synchroniser for asynchronous conduit inputs.
// Latency: 2 clk cycles.
// Backpressure: none.
module f6_sync2 #(
   parameter int       W       = 1,
   parameter logic     RST_VAL = 1'b0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   // Metastability stage followed by the stable output stage
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= {W{RST_VAL}};
         r_sync <= {W{RST_VAL}};
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule : f6_sync2

// File: rtl/f6_adc_acq.sv
// MCP3201-style serial ADC sequencer: generates cs_n/clk_adc, deserialises 12 bits, checks the null bit.
// Latency: adc_valid 31*HALF_DIV cycles after cs_n falls; continuous frames every 31*HALF_DIV+CSH_CYCLES.
// Backpressure: none; start is ignored while busy, samples must be taken on the adc_valid strobe.
import f6_pkg::*;

module f6_adc_acq #(
   parameter int HALF_DIV   = 25,
   parameter int CSH_CYCLES = 50,
   parameter int N_BITS     = ADC_BITS
) (
   input  logic          clk_clk,
   input  logic          reset_reset,
   f6_adc_acq_if.master  bus
);
   localparam int CNT_MAX = (HALF_DIV > CSH_CYCLES) ? HALF_DIV : CSH_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int BIT_W   = 4;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [BIT_W-1:0]    r_bit;
   logic                r_hi;
   logic [N_BITS-1:0]   r_shift;
   logic                r_ferr;
   logic [N_BITS-1:0]   r_adc_data;
   logic                r_adc_valid;
   logic                r_null_err;

   logic                w_din;
   logic                w_half_end;
   logic                w_csh_end;
   logic                w_sample;
   logic                w_frame_end;
   logic                w_cs_n;
   logic                w_clk_adc;
   logic                w_busy;

   // DOUT arrives from another clock domain; all sampling uses the synchronised copy
   f6_sync2 #(
      .W       (1),
      .RST_VAL (1'b0)
   ) u_sync_din (
      .i_clk (clk_clk),
      .i_rst (reset_reset),
      .i_d   (bus.data_in),
      .o_q   (w_din)
   );

   assign w_half_end  = (r_cnt == CNT_W'(HALF_DIV - 1));
   assign w_csh_end   = (r_cnt == CNT_W'(CSH_CYCLES - 1));
   // Last system cycle of a clk_adc high phase: DOUT has been stable for a whole half period
   assign w_sample    = (r_state == SHIFT) && r_hi && w_half_end;
   // Last low-phase cycle of the final clk_adc period
   assign w_frame_end = (r_state == SHIFT) && !r_hi && w_half_end &&
                        (r_bit == BIT_W'(ADC_FRAME_CLKS));

   // State register
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (bus.start || bus.continuous) w_next = SETUP;
         SETUP: if (w_half_end)                  w_next = SHIFT;
         SHIFT: if (w_frame_end)                 w_next = HOLD;
         HOLD:  if (w_csh_end)                   w_next = bus.continuous ? SETUP : IDLE;
         default:                                w_next = IDLE;
      endcase
   end

   // Pin and status decode from the state; reset forces IDLE so pins idle immediately
   always_comb begin
      w_cs_n    = 1'b1;
      w_clk_adc = 1'b0;
      w_busy    = 1'b0;
      case (r_state)
         SETUP: begin
            w_cs_n = 1'b0;
            w_busy = 1'b1;
         end
         SHIFT: begin
            w_cs_n    = 1'b0;
            w_clk_adc = r_hi;
            w_busy    = 1'b1;
         end
         HOLD: begin
            w_busy = 1'b1;
         end
         default: begin
            w_cs_n    = 1'b1;
            w_clk_adc = 1'b0;
            w_busy    = 1'b0;
         end
      endcase
   end

   // Phase timer: restarts on every state change and on every clk_adc half-period boundary
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_cnt <= '0;
      end else if ((r_state != w_next) || (r_state == IDLE) ||
                   ((r_state == SHIFT) && w_half_end)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // clk_adc phase and period index k (1..15, never wraps within a frame)
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_hi  <= 1'b0;
         r_bit <= BIT_W'(1);
      end else if ((r_state == SETUP) && w_half_end) begin
         r_hi  <= 1'b1;
         r_bit <= BIT_W'(1);
      end else if (w_frame_end) begin
         r_hi  <= 1'b0;
      end else if ((r_state == SHIFT) && w_half_end) begin
         r_hi <= !r_hi;
         if (!r_hi) begin
            r_bit <= r_bit + BIT_W'(1);
         end
      end
   end

   // Null-bit check and MSB-first deserialisation; k=1,2 are the ADC's sample/Hi-Z periods
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_shift <= '0;
         r_ferr  <= 1'b0;
      end else if (r_state == SETUP) begin
         r_ferr  <= 1'b0;
      end else if (w_sample) begin
         if ((r_bit == BIT_W'(ADC_NULL_BIT_IDX)) && w_din) begin
            r_ferr <= 1'b1;
         end
         if (r_bit > BIT_W'(ADC_NULL_BIT_IDX)) begin
            r_shift <= {r_shift[N_BITS-2:0], w_din};
         end
      end
   end

   // Sample publication: adc_data/null_err change only together with the one-cycle strobe
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_adc_data  <= '0;
         r_null_err  <= 1'b0;
         r_adc_valid <= 1'b0;
      end else begin
         r_adc_valid <= w_frame_end;
         if (w_frame_end) begin
            r_adc_data <= r_shift;
            r_null_err <= r_ferr;
         end
      end
   end

   assign bus.cs_n      = w_cs_n;
   assign bus.clk_adc   = w_clk_adc;
   assign bus.busy      = w_busy;
   assign bus.adc_data  = r_adc_data;
   assign bus.adc_valid = r_adc_valid;
   assign bus.null_err  = r_null_err;
endmodule : f6_adc_acq

// File: tb/tb_f6_adc_acq.sv
// Bench for f6_adc_acq: MCP3201 pin model plus a frame-timing reference model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_f6_adc_acq;
   localparam int HD     = 25;
   localparam int CSH    = 50;
   localparam int T_VAL  = 31 * HD;          // cs_n fall to adc_valid
   localparam int T_FRM  = 31 * HD + CSH;    // full frame incl. hold

   logic clk_clk = 1'b0;
   logic reset_reset;

   f6_adc_acq_if #(.N_BITS(12)) bus ();

   f6_adc_acq #(
      .HALF_DIV   (HD),
      .CSH_CYCLES (CSH),
      .N_BITS     (12)
   ) dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .bus         (bus)
   );

   always #10 clk_clk = ~clk_clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- ADC pin model ----------------
   // Each frame entry: bit 12 = null bit driven at k=3, bits 11:0 = code.
   logic [12:0] stim_q[$];
   logic [12:0] pend_q[$];
   logic [12:0] a_cur = '0;
   logic        a_prev_cs = 1'b1;
   logic        a_prev_clk = 1'b0;
   int          a_nfall = 0;

   function automatic logic adc_bit(input logic [12:0] f, input int k);
      if (k == 3) return f[12];
      if (k >= 4 && k <= 15) return f[15-k];
      return 1'($urandom);
   endfunction

   // MCP3201 changes DOUT after each clk_adc falling edge; data for period k after fall k-1
   always @(posedge clk_clk) begin
      #2;
      if (reset_reset) begin
         bus.data_in = 1'b0;
         a_nfall     = 0;
      end else if (a_prev_cs && !bus.cs_n) begin
         if (stim_q.size() > 0) a_cur = stim_q.pop_front();
         else                   a_cur = 13'($urandom);
         pend_q.push_back(a_cur);
         a_nfall     = 0;
         bus.data_in = adc_bit(a_cur, 1);
      end else if (a_prev_clk && !bus.clk_adc && !bus.cs_n) begin
         a_nfall++;
         bus.data_in = adc_bit(a_cur, a_nfall + 1);
      end
      a_prev_cs  = bus.cs_n;
      a_prev_clk = bus.clk_adc;
   end

   // ---------------- reference model + per-cycle compare ----------------
   bit          m_act = 1'b0;
   int          m_t0  = 0;
   logic [11:0] m_data = '0;
   logic        m_null = 1'b0;
   logic        c_prev_cs = 1'b1;
   int          csfall_cyc = 0;
   logic        s_rst, s_start, s_cont;
   int          o;
   logic        e_cs, e_clk, e_busy, e_valid;

   always @(posedge clk_clk) begin
      s_rst   = reset_reset;
      s_start = bus.start;
      s_cont  = bus.continuous;
      cyc++;
      #1;
      if (s_rst) begin
         m_act  = 1'b0;
         m_data = '0;
         m_null = 1'b0;
         pend_q.delete();
      end else if (m_act) begin
         if (cyc - m_t0 == T_FRM) begin
            if (s_cont) m_t0 = cyc;
            else        m_act = 1'b0;
         end
      end else if (s_start || s_cont) begin
         m_act = 1'b1;
         m_t0  = cyc;
      end
      o       = cyc - m_t0;
      e_cs    = !(m_act && o < T_VAL);
      e_busy  = m_act;
      e_clk   = m_act && o >= HD && o < T_VAL && ((o - HD) % (2*HD)) < HD;
      e_valid = m_act && (o == T_VAL);
      if (e_valid) begin
         if (pend_q.size() == 0) begin
            chk("model_frame_pending", 0, 1);
         end else begin
            {m_null, m_data} = pend_q.pop_front();
         end
      end
      chk("cs_n",      bus.cs_n,      e_cs);
      chk("clk_adc",   bus.clk_adc,   e_clk);
      chk("busy",      bus.busy,      e_busy);
      chk("adc_valid", bus.adc_valid, e_valid);
      chk("adc_data",  bus.adc_data,  m_data);
      chk("null_err",  bus.null_err,  m_null);
      if (c_prev_cs && !bus.cs_n) csfall_cyc = cyc;
      c_prev_cs = bus.cs_n;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   task automatic pulse_start;
      bus.start = 1'b1;
      @(negedge clk_clk);
      bus.start = 1'b0;
   endtask

   // Advances at least one cycle, then waits for the strobe; returns its cycle index
   task automatic wait_valid(input int budget, output int vcyc);
      int n = 0;
      do begin
         @(negedge clk_clk);
         n++;
      end while (!bus.adc_valid && n < budget);
      chk("valid_seen", bus.adc_valid, 1'b1);
      vcyc = bus.adc_valid ? cyc : -1;
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (bus.busy && n < budget) begin
         @(negedge clk_clk);
         n++;
      end
      chk("idle_reached", bus.busy, 1'b0);
   endtask

   task automatic count_valid(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         @(negedge clk_clk);
         if (bus.adc_valid) cnt++;
      end
   endtask

   initial begin : watchdog
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int v1, v2, v3, n, cnt;
      logic [11:0] code;
      reset_reset    = 1'b1;
      bus.start      = 1'b0;
      bus.continuous = 1'b0;
      tick(5);
      chk("rst_cs_n",    bus.cs_n,      1'b1);
      chk("rst_clk_adc", bus.clk_adc,   1'b0);
      chk("rst_busy",    bus.busy,      1'b0);
      chk("rst_valid",   bus.adc_valid, 1'b0);
      chk("rst_data",    bus.adc_data,  12'h000);
      reset_reset = 1'b0;

      // Idle after reset
      count_valid(100, cnt);
      chk("idle_valid_cnt", cnt, 0);
      chk("idle_cs_n", bus.cs_n, 1'b1);

      // Single shot, code 0xA5C
      stim_q.push_back({1'b0, 12'hA5C});
      pulse_start();
      wait_valid(2000, v1);
      chk("ss_data",   bus.adc_data, 12'hA5C);
      chk("ss_null",   bus.null_err, 1'b0);
      chk("ss_cs_hi",  bus.cs_n,     1'b1);
      chk("ss_lat",    v1 - csfall_cyc, 775);
      wait_idle(200, n);
      chk("ss_hold",   n, 50);

      // Continuous: 0x000, 0xFFF, 0x801
      stim_q.push_back({1'b0, 12'h000});
      stim_q.push_back({1'b0, 12'hFFF});
      stim_q.push_back({1'b0, 12'h801});
      bus.continuous = 1'b1;
      wait_valid(2000, v1);
      chk("cont_d0", bus.adc_data, 12'h000);
      wait_valid(2000, v2);
      chk("cont_d1", bus.adc_data, 12'hFFF);
      chk("cont_p1", v2 - v1, 825);
      wait_valid(2000, v3);
      chk("cont_d2", bus.adc_data, 12'h801);
      chk("cont_p2", v3 - v2, 825);
      bus.continuous = 1'b0;
      wait_idle(200, n);

      // Null bit set, then clean frame
      stim_q.push_back({1'b1, 12'h123});
      pulse_start();
      wait_valid(2000, v1);
      chk("null_data", bus.adc_data, 12'h123);
      chk("null_err1", bus.null_err, 1'b1);
      wait_idle(200, n);
      code = 12'($urandom);
      stim_q.push_back({1'b0, code});
      pulse_start();
      wait_valid(2000, v1);
      chk("null_data2", bus.adc_data, code);
      chk("null_err0",  bus.null_err, 1'b0);
      wait_idle(200, n);

      // start mid-SHIFT of frame 2, continuous dropped during frame 2
      bus.continuous = 1'b1;
      wait_valid(2000, v1);
      tick(300);
      pulse_start();
      tick(100);
      bus.continuous = 1'b0;
      wait_valid(2000, v2);
      chk("drop_p", v2 - v1, 825);
      wait_idle(200, n);
      count_valid(1000, cnt);
      chk("drop_no_extra", cnt, 0);

      // Reset in k=8 high phase
      pulse_start();
      n = 0;
      while (bus.cs_n && n < 100) begin
         @(negedge clk_clk);
         n++;
      end
      chk("rst_frame_started", bus.cs_n, 1'b0);
      tick(HD + 7*2*HD + 10);
      chk("pre_rst_clk", bus.clk_adc, 1'b1);
      reset_reset = 1'b1;
      #1;
      chk("mid_rst_cs_n",  bus.cs_n,      1'b1);
      chk("mid_rst_clk",   bus.clk_adc,   1'b0);
      chk("mid_rst_data",  bus.adc_data,  12'h000);
      chk("mid_rst_valid", bus.adc_valid, 1'b0);
      tick(3);
      reset_reset = 1'b0;
      count_valid(900, cnt);
      chk("post_rst_no_valid", cnt, 0);
      stim_q.push_back({1'b0, 12'h3C6});
      pulse_start();
      wait_valid(2000, v1);
      chk("post_rst_data", bus.adc_data, 12'h3C6);
      chk("post_rst_null", bus.null_err, 1'b0);
      wait_idle(200, n);

      // Randomised start/continuous activity; checked by the per-cycle model
      for (int i = 0; i < 6; i++) begin
         bus.continuous = 1'($urandom);
         repeat ($urandom_range(2, 6)) begin
            tick($urandom_range(50, 400));
            pulse_start();
         end
         tick($urandom_range(100, 1500));
         bus.continuous = 1'b0;
      end
      wait_idle(1000, n);
      tick(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule : tb_f6_adc_acq
